// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; result WIDTH+2 cycles after start.
// No backpressure: start is only accepted in IDLE, and start or HI/LO writes seen while busy are dropped.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_q, mag_d;     // multiplicand |a| (mul) or divisor |b| (div)
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product; low half is the quotient in divide
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               in_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        in_signed = ~op[0];
        abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mag_q} : {(WIDTH+1){1'b0}});
        rem_shift = {rem_q, acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_q};
        prod_fix  = neg_res_q ? -acc_q : acc_q;
        quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -rem_q : rem_q;

        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wd;
                if (lo_we) lo_d = wd;
                if (start) begin
                    state_d   = S_CALC;
                    op_d      = op;
                    cnt_d     = CW'(WIDTH - 1);
                    rem_d     = '0;
                    div0_d    = op[1] && (b == '0);
                    neg_res_d = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = in_signed && a[WIDTH-1];
                    if (op[1]) begin
                        mag_d = abs_b;
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        mag_d = abs_a;
                        acc_d = {{WIDTH{1'b0}}, abs_b};
                    end
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                    rem_d = rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (op_q[1]) begin
                    // With a zero divisor the remainder path already yields the raw dividend.
                    hi_d = rem_fix;
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed vectors, randomized ops against an arithmetic model,
// handshake corner cases, HI/LO direct writes and mid-operation reset.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wd;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    logic [1:0]  d_op [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] d_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
    logic [31:0] d_b  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
    logic [31:0] d_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd5};
    logic [31:0] d_lo [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'h80000000, 32'hFFFFFFFF};
    logic        d_z  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy, p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = ux * uy;
            2'b10: p = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
            default: p = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
        endcase
        return p;
    endfunction

    // Caller is at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; returns at the negedge of the done cycle, lat = -1 on timeout.
    task automatic wait_done(input int first, output int lat, output bit busy_ok);
        int cyc;
        cyc     = first;
        lat     = -1;
        busy_ok = 1'b1;
        while (cyc <= 80) begin
            if (done === 1'b1) begin
                lat = cyc;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'b00; a = '0; b = '0; wd = '0;
        repeat (3) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (div0 !== 1'b0) $display("FAIL reset_div0 got %b want 0", div0); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        int lat;
        bit bok;
        for (int i = 0; i < 6; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_done(1, lat, bok);
            total_cnt++; if (lat != 34) $display("FAIL dir%0d_latency got %0d want 34", i, lat); else pass_cnt++;
            total_cnt++; if (!bok) $display("FAIL dir%0d_busy busy not high exactly in cycles 1..33", i); else pass_cnt++;
            total_cnt++; if (hi !== d_hi[i]) $display("FAIL dir%0d_hi got %h want %h", i, hi, d_hi[i]); else pass_cnt++;
            total_cnt++; if (lo !== d_lo[i]) $display("FAIL dir%0d_lo got %h want %h", i, lo, d_lo[i]); else pass_cnt++;
            total_cnt++; if (div0 !== d_z[i]) $display("FAIL dir%0d_div0 got %b want %b", i, div0, d_z[i]); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL dir%0d_pulse done=%b busy=%b want 0 0", i, done, busy); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat;
        bit bok;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: y = $urandom_range(1, 15);
                3: x = $urandom_range(0, 1000);
                default: ;
            endcase
            exp = model(o, x, y);
            issue(o, x, y);
            wait_done(1, lat, bok);
            total_cnt++; if (lat != 34) $display("FAIL rnd%0d_latency got %0d want 34", i, lat); else pass_cnt++;
            total_cnt++; if (hi !== exp[63:32]) $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, o, x, y, hi, exp[63:32]); else pass_cnt++;
            total_cnt++; if (lo !== exp[31:0]) $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, o, x, y, lo, exp[31:0]); else pass_cnt++;
            total_cnt++; if (div0 !== (o[1] && y == 32'd0)) $display("FAIL rnd%0d_div0 got %b", i, div0); else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        bit bok;
        logic [63:0] exp;
        exp = model(2'b00, 32'hFFFFFF00, 32'd12345);
        issue(2'b00, 32'hFFFFFF00, 32'd12345);
        repeat (9) @(negedge clk);
        issue(2'b11, 32'd77, 32'd0);
        wait_done(11, lat, bok);
        total_cnt++; if (lat != 34) $display("FAIL ign_latency got %0d want 34", lat); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== exp) $display("FAIL ign_result got %h%h want %h", hi, lo, exp); else pass_cnt++;
        total_cnt++; if (div0 !== 1'b0) $display("FAIL ign_div0 got %b want 0", div0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        logic [63:0] e1, e2;
        e1 = model(2'b10, 32'd1000, 32'hFFFFFFFD);
        e2 = model(2'b01, 32'hDEADBEEF, 32'h00C0FFEE);
        issue(2'b10, 32'd1000, 32'hFFFFFFFD);
        wait_done(1, lat, bok);
        total_cnt++; if ({hi, lo} !== e1) $display("FAIL b2b_first got %h%h want %h", hi, lo, e1); else pass_cnt++;
        issue(2'b01, 32'hDEADBEEF, 32'h00C0FFEE);
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept busy got %b want 1", busy); else pass_cnt++;
        wait_done(1, lat, bok);
        total_cnt++; if (lat != 34) $display("FAIL b2b_latency got %0d want 34", lat); else pass_cnt++;
        total_cnt++; if ({hi, lo} !== e2) $display("FAIL b2b_second got %h%h want %h", hi, lo, e2); else pass_cnt++;
    endtask

    task automatic test_hilo_write();
        int lat;
        bit bok;
        issue(2'b01, 32'd2, 32'd3);
        wait_done(1, lat, bok);
        @(negedge clk);
        issue(2'b01, 32'd4, 32'd5);
        hi_we = 1'b1; lo_we = 1'b1; wd = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        total_cnt++; if (hi !== 32'd0) $display("FAIL busy_mthi got %h want 0", hi); else pass_cnt++;
        total_cnt++; if (lo !== 32'd6) $display("FAIL busy_mtlo got %h want 6", lo); else pass_cnt++;
        wait_done(2, lat, bok);
        total_cnt++; if (lo !== 32'd20 || hi !== 32'd0) $display("FAIL busy_result got %h%h want 0x14", hi, lo); else pass_cnt++;
        @(negedge clk);
        hi_we = 1'b1; wd = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        total_cnt++; if (hi !== 32'h1234) $display("FAIL idle_mthi got %h want 1234", hi); else pass_cnt++;
        lo_we = 1'b1; wd = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        total_cnt++; if (lo !== 32'h5678 || hi !== 32'h1234) $display("FAIL idle_mtlo hi=%h lo=%h want 1234 5678", hi, lo); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bok;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_ctrl busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        total_cnt++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL rstmid_hilo got %h %h want 0 0", hi, lo); else pass_cnt++;
        reset = 1'b0;
        issue(2'b11, 32'd100, 32'd7);
        wait_done(1, lat, bok);
        total_cnt++; if (lat != 34) $display("FAIL rstmid_latency got %0d want 34", lat); else pass_cnt++;
        total_cnt++; if (lo !== 32'd14 || hi !== 32'd2) $display("FAIL rstmid_result got hi=%h lo=%h want 2 e", hi, lo); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_hilo_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the MIPS core, parametrised in operand width. It executes MULT, MULTU, DIV and DIVU over multiple cycles alongside the datapath, and exposes a start/busy/done handshake so the controller can stall on MFHI/MFLO. The HI/LO registers are also directly writable for MTHI/MTLO.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- clk  in  1  core clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand/dividend), captured when start is accepted.
- b  in  WIDTH  rt operand (multiplier/divisor), captured when start is accepted.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wd  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: hi/lo hold a new result.
- div0  out  1  last division had b == 0; held until the next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation

- The unit has three states: IDLE, CALC and FIX.
- IDLE → CALC when start = 1.
  - Latch op.
  - Latch magnitudes |a| and |b|. Signed ops take the two's-complement absolute value; unsigned ops use the operands as-is.
  - Latch the result sign bits and a step counter cnt = WIDTH-1.
  - Clear div0. Set div0 = 1 if the op is a divide and b == 0.
- CALC performs one step per cycle.
  - Multiply: shift-add, one multiplier bit per step, into a 2·WIDTH-bit accumulator.
  - Divide: restoring division, one quotient bit per step, with a (WIDTH+1)-bit partial remainder.
  - cnt decrements each step. At cnt == 0 the state goes to FIX.
- FIX applies the sign fix-up and writes the result, then goes to IDLE.
  - Signed multiply: negate the 2·WIDTH product if sign(a) ≠ sign(b).
  - Signed divide: the quotient is negated if the operand signs differ (truncation toward zero). The remainder takes the sign of the dividend.
  - Multiply writes {hi, lo} = the 2·WIDTH-bit product.
  - Divide writes lo = quotient and hi = remainder.
- Division by zero: the result is lo = all ones and hi = a (raw input value), for both DIV and DIVU. Latency is unchanged.
- Signed overflow: DIV with a = −2^(WIDTH−1) and b = −1 gives lo = 0x8000_0000 and hi = 0 (for WIDTH = 32). This is wraparound, no trap.
- Direct writes (hi_we/lo_we) take effect only in IDLE and when no FIX write happens the same edge.
  - If hi_we or lo_we is asserted while busy = 1, the write is dropped.
- start while busy = 1 is ignored; it is not queued.
- All arithmetic is modulo 2^WIDTH per register. No x/z values are allowed on any output after reset.

## Timing

- Reset: state = IDLE, busy = 0, done = 0, div0 = 0, hi = 0, lo = 0, cnt = 0.
- Reset asserted mid-operation aborts the operation. On the next edge all outputs return to the reset values and no partial result is written.
- Let edge 0 be the edge at which start is accepted.
  - busy = 1 during cycles 1 … WIDTH+1 (CALC for WIDTH cycles, then FIX for 1 cycle).
  - At edge WIDTH+1, hi/lo are updated and done is set.
  - In cycle WIDTH+2, done = 1, busy = 0, and the new hi/lo are visible.
  - For WIDTH = 32: done in cycle 34, i.e. 34 cycles after the start edge.
- done is high for exactly one cycle.
- start asserted in the done cycle is accepted: back-to-back operations have no gap cycle.
- busy and done are registered outputs; there is no combinational path from any input.
- hi_we/lo_we write at the same edge they are sampled. The new value is visible the next cycle.

## Test plan

- MULTU, WIDTH = 32: a = 0xFFFF_FFFF, b = 0xFFFF_FFFF → done in cycle 34, hi = 0xFFFF_FFFE, lo = 0x0000_0001; busy = 1 in cycles 1–33 only.
- MULT: a = −3 (0xFFFF_FFFD), b = 7 → hi = 0xFFFF_FFFF, lo = 0xFFFF_FFEB (−21).
- DIV: a = −7, b = 2 → lo = 0xFFFF_FFFD (−3), hi = 0xFFFF_FFFF (−1).
- DIVU: a = 100, b = 7 → lo = 14, hi = 2, div0 = 0.
- DIV: a = 0x8000_0000, b = 0xFFFF_FFFF → lo = 0x8000_0000, hi = 0.
- DIVU: a = 5, b = 0 → div0 = 1, lo = 0xFFFF_FFFF, hi = 5, done in cycle 34.
- Handshakes and writes:
  - start pulsed mid-CALC is ignored.
  - start in the done cycle begins the next operation immediately.
  - hi_we with wd = 0x1234 while busy leaves hi unchanged.
  - hi_we with wd = 0x1234 in IDLE gives hi = 0x1234 the next cycle.
- Reset asserted in cycle 10 of a MULTU → the next cycle has busy = 0, done = 0, hi = lo = 0. A new start afterwards completes normally.
